pic_irr_sync: RTL and testbench

Clocked, parametrised interrupt request register for the PIC. It synchronises NUM_IRQ asynchronous request lines and captures them in edge- or level-triggered mode selected by LTIM. It clears individual bits on acknowledge from the in-service logic and presents masked pending status plus the highest-priority pending index to the priority resolver.

---
 rtl/pic_pkg.sv | 28 ++
 rtl/pic_sync_bit.sv | 32 +++
 rtl/pic_irr_sync.sv | 110 +++++++++++
 tb/tb_pic_irr_sync.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: definitions shared by the PIC blocks.
//   LTIM_EDGE / LTIM_LEVEL : trigger-mode encodings of the ltim input
//   NUM_IRQ_DEFAULT        : default number of request channels
//   lsb_idx()              : index of the lowest set bit of a 32-bit vector
//                            (0 when the vector is empty); channel 0 is the
//                            highest priority, so this is the priority encoder
package pic_pkg;

  localparam logic LTIM_EDGE  = 1'b0;
  localparam logic LTIM_LEVEL = 1'b1;

  localparam int NUM_IRQ_DEFAULT = 8;

  // Scan from the top down so the last hit written is the lowest set bit.
  function automatic logic [4:0] lsb_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_sync_bit.sv
// pic_sync_bit: STAGES-deep single-bit synchroniser for one asynchronous
// request line.
// Ports:
//   clk      in  block clock
//   reset_n  in  asynchronous active-low reset, clears every stage
//   d        in  asynchronous input
//   q        out synchronised output (last stage)
module pic_sync_bit
  import pic_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/pic_irr_sync.sv
// pic_irr_sync: interrupt request register of the PIC.
// Synchronises NUM_IRQ request lines, captures them edge- or level-triggered
// (ltim), clears bits on acknowledge and reports the masked pending status
// together with the highest-priority (lowest-numbered) pending channel.
// Ports:
//   clk        in  block clock
//   reset_n    in  asynchronous active-low reset
//   ltim       in  1 = level-triggered, 0 = edge-triggered
//   ir         in  asynchronous request lines, bit i = IRi
//   imr        in  interrupt mask, 1 = masked (never alters irr)
//   ack_valid  in  single-cycle acknowledge strobe
//   ack_idx    in  channel being acknowledged
//   irr        out request register
//   int_req    out any unmasked bit pending
//   pend_idx   out lowest-numbered unmasked pending channel (0 if none)
//   pend_valid out pend_idx meaningful (same as int_req)
module pic_irr_sync
  import pic_pkg::*;
#(
  parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ltim,
  input  logic [NUM_IRQ-1:0] ir,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               ack_valid,
  input  logic [IDX_W-1:0]   ack_idx,
  output logic [NUM_IRQ-1:0] irr,
  output logic               int_req,
  output logic [IDX_W-1:0]   pend_idx,
  output logic               pend_valid
);

  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] prev_r;
  logic               ltim_r;
  logic [NUM_IRQ-1:0] irr_r;
  logic [NUM_IRQ-1:0] irr_next_s;
  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] ack_mask_s;
  logic [NUM_IRQ-1:0] masked_s;
  logic               mode_chg_s;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    pic_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (ir[g]),
      .q       (sync_s[g])
    );
  end

  // Next-state of the request register: edge detect, ack clear, mode change.
  always_comb begin
    rise_s     = sync_s & ~prev_r;
    mode_chg_s = (ltim != ltim_r);
    ack_mask_s = '0;
    irr_next_s = irr_r;
    // An out-of-range ack_idx matches no channel, so it is ignored for free.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_valid && (ack_idx == IDX_W'(i))) begin
        ack_mask_s[i] = 1'b1;
      end else begin
        ack_mask_s[i] = 1'b0;
      end
    end
    if (mode_chg_s) begin
      // Drop everything and suppress sets; prev reloads from sync below so
      // the new mode cannot see a stale edge.
      irr_next_s = '0;
    end else if (ltim == LTIM_LEVEL) begin
      // Level mode follows the line: a high line wins over ack, a low line
      // clears regardless of ack.
      irr_next_s = sync_s;
    end else begin
      // Edge mode: sticky until ack; a coincident new edge wins over ack.
      irr_next_s = (irr_r & ~ack_mask_s) | rise_s;
    end
  end

  // State registers: edge-detect history, mode copy and request register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= '0;
      ltim_r <= LTIM_EDGE;
      irr_r  <= '0;
    end else begin
      prev_r <= sync_s;
      ltim_r <= ltim;
      irr_r  <= irr_next_s;
    end
  end

  // Masked status and priority encode are combinational so a mask change
  // is seen by the resolver in the same cycle.
  always_comb begin
    masked_s   = irr_r & ~imr;
    int_req    = |masked_s;
    pend_valid = |masked_s;
    pend_idx   = IDX_W'(lsb_idx(32'(masked_s)));
  end

  assign irr = irr_r;

endmodule

// File: tb/tb_pic_irr_sync.sv
module tb_pic_irr_sync;

  localparam int NI = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ltim = 1'b0;
  logic [NI-1:0] ir = '0;
  logic [NI-1:0] imr = '0;
  logic          ack_valid = 1'b0;
  logic [2:0]    ack_idx = 3'd0;
  logic [NI-1:0] irr;
  logic          int_req;
  logic [2:0]    pend_idx;
  logic          pend_valid;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [NI-1:0] m_sync [SS];
  logic [NI-1:0] m_prev;
  logic          m_ltim;
  logic [NI-1:0] m_irr;
  logic [NI-1:0] exp_q [$];

  pic_irr_sync #(
    .NUM_IRQ     (NI),
    .SYNC_STAGES (SS),
    .IDX_W       (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ltim       (ltim),
    .ir         (ir),
    .imr        (imr),
    .ack_valid  (ack_valid),
    .ack_idx    (ack_idx),
    .irr        (irr),
    .int_req    (int_req),
    .pend_idx   (pend_idx),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_pend(input logic [NI-1:0] v);
    logic [2:0] r;
    logic found;
    r = 3'd0;
    found = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (v[i] && !found) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_sync[k] = '0;
    m_prev = '0;
    m_ltim = 1'b0;
    m_irr  = '0;
  endtask

  task automatic chk_outputs(input logic [NI-1:0] e);
    chk("int_req", {31'd0, int_req}, {31'd0, |(e & ~imr)});
    chk("pend_valid", {31'd0, pend_valid}, {31'd0, |(e & ~imr)});
    chk("pend_idx", {29'd0, pend_idx}, {29'd0, exp_pend(e & ~imr)});
  endtask

  // One clock: predict, push, clock, pop and compare. Called at negedge.
  task automatic step();
    logic [NI-1:0] s, rise, nirr, e;
    s = m_sync[SS-1];
    rise = s & ~m_prev;
    for (int i = 0; i < NI; i++) begin
      if (ltim != m_ltim) nirr[i] = 1'b0;
      else if (ltim) nirr[i] = s[i];
      else if (rise[i]) nirr[i] = 1'b1;
      else if (ack_valid && (ack_idx == 3'(i))) nirr[i] = 1'b0;
      else nirr[i] = m_irr[i];
    end
    exp_q.push_back(nirr);
    @(posedge clk);
    m_prev = s;
    m_ltim = ltim;
    m_irr  = nirr;
    for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = ir;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("irr", {24'd0, irr}, {24'd0, e});
    chk_outputs(e);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic ack(input logic [2:0] idx);
    ack_valid = 1'b1;
    ack_idx = idx;
    step();
    ack_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    // reset with all lines high, edge mode
    ir = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_irr", {24'd0, irr}, 32'h0);
    chk("rst_int_req", {31'd0, int_req}, 32'h0);
    chk("rst_pend_valid", {31'd0, pend_valid}, 32'h0);
    chk("rst_pend_idx", {29'd0, pend_idx}, 32'h0);
    reset_n = 1'b1;
    steps(2);
    chk("rel_lat_lo", {24'd0, irr}, 32'h0);
    step();
    chk("rel_irr", {24'd0, irr}, 32'hFF);
    chk("rel_int_req", {31'd0, int_req}, 32'h1);
    chk("rel_pend_idx", {29'd0, pend_idx}, 32'h0);

    // clear everything, held-high lines must not re-trigger
    ir = 8'h00;
    for (int i = 0; i < NI; i++) ack(3'(i));
    steps(3);
    chk("cleared", {24'd0, irr}, 32'h0);

    // edge: pulse ir[5] for 3 cycles
    ir = 8'h20;
    steps(3);
    ir = 8'h00;
    steps(6);
    chk("edge_sticky", {24'd0, irr}, 32'h20);
    ack(3'd5);
    chk("edge_ack", {24'd0, irr}, 32'h0);
    steps(5);
    chk("edge_no_retrig", {24'd0, irr}, 32'h0);

    // edge: ir[2] rise coincides with its ack
    ir = 8'h04;
    steps(3);
    ir = 8'h00;
    steps(3);
    ir = 8'h04;
    steps(2);
    ack(3'd2);
    chk("set_wins_edge", {31'd0, irr[2]}, 32'h1);
    ack(3'd2);
    chk("ack_held_line", {31'd0, irr[2]}, 32'h0);

    // masking
    ir = 8'h00;
    steps(3);
    ir = 8'h0C;
    steps(3);
    chk("mask_setup", {24'd0, irr}, 32'h0C);
    imr = 8'h04;
    #1;
    chk("mask_pend_idx", {29'd0, pend_idx}, 32'h3);
    chk("mask_int_req", {31'd0, int_req}, 32'h1);
    imr = 8'h0C;
    #1;
    chk("mask_all_int_req", {31'd0, int_req}, 32'h0);
    chk("mask_all_pend_valid", {31'd0, pend_valid}, 32'h0);
    chk("mask_irr_kept", {24'd0, irr}, 32'h0C);
    @(negedge clk);
    m_sync[0] = ir;  // keep model aligned across the idle cycle
    m_prev = m_sync[SS-1];
    imr = 8'h00;
    ack(3'd2);
    ack(3'd3);
    chk("mask_cleanup", {24'd0, irr}, 32'h0);

    // mode change 0 -> 1 with irr = 81
    ir = 8'h00;
    steps(3);
    ir = 8'h81;
    steps(3);
    chk("mc_setup", {24'd0, irr}, 32'h81);
    ltim = 1'b1;
    step();
    chk("mc_clear", {24'd0, irr}, 32'h0);
    step();
    chk("mc_reload", {24'd0, irr}, 32'h81);

    // level: held line survives ack, drop takes SS+1 edges
    ir = 8'h89;
    steps(3);
    chk("lvl_set", {24'd0, irr}, 32'h89);
    ack(3'd3);
    chk("lvl_set_wins", {31'd0, irr[3]}, 32'h1);
    ir = 8'h81;
    steps(2);
    chk("lvl_drop_lat", {31'd0, irr[3]}, 32'h1);
    step();
    chk("lvl_drop", {31'd0, irr[3]}, 32'h0);

    // asynchronous reset mid-operation
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_irr", {24'd0, irr}, 32'h0);
    chk("mid_rst_int_req", {31'd0, int_req}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    steps(4);
    chk("post_rst_level", {24'd0, irr}, 32'h81);

    // randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      ir = NI'($urandom);
      imr = NI'($urandom);
      ack_valid = ($urandom_range(0, 2) == 0);
      ack_idx = 3'($urandom_range(0, NI - 1));
      if ($urandom_range(0, 15) == 0) ltim = ~ltim;
      step();
    end
    ack_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
